// File: rtl/seg_disp_ctrl.sv
// Multi-digit seven-segment controller on an Avalon-MM slave: hex/raw, blank, blink.
// Define SEG_DISP_BLINK_EN to build the blink registers, counter and phase logic.
module seg_disp_ctrl #(
  parameter int NUM_DIGITS = 7,
  parameter int CLK_HZ     = 50000000,
  parameter int BLINK_HZ   = 2,
  parameter bit ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4:0]              avs_address,
  input  logic                    avs_write,
  input  logic [31:0]             avs_writedata,
  input  logic                    avs_read,
  output logic [31:0]             avs_readdata,
  output logic [NUM_DIGITS*7-1:0] seg_out
);

  localparam logic [4:0] A_BLANK  = 5'd16;
  localparam logic [4:0] A_BLINK  = 5'd17;
  localparam logic [4:0] A_DIV    = 5'd18;
  localparam logic [4:0] A_STATUS = 5'd19;
  localparam logic [6:0] SEG_OFF  = ACTIVE_LOW ? 7'h7F : 7'h00;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [7:0]            digit_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] blank_q;
  logic [NUM_DIGITS-1:0] blink_off;
  logic                  phase;
  logic                  wr_blank;
  logic [31:0]           rd_d;
  logic [NUM_DIGITS*7-1:0] seg_d;
  logic [6:0]            pat;
  logic                  unused_wdata;

  assign wr_blank     = avs_write && (avs_address == A_BLANK);
  assign unused_wdata = ^avs_writedata[31:8];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++)
        digit_q[i] <= 8'h00;
    end else if (avs_write) begin
      for (int i = 0; i < NUM_DIGITS; i++)
        if (avs_address == 5'(i))
          digit_q[i] <= avs_writedata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      blank_q <= '1;
    else if (wr_blank)
      blank_q <= avs_writedata[NUM_DIGITS-1:0];
  end

`ifdef SEG_DISP_BLINK_EN
  localparam logic [31:0] DIV_RST = 32'(CLK_HZ / (2 * BLINK_HZ));

  logic [NUM_DIGITS-1:0] blink_q;
  logic [31:0]           div_q;
  logic [31:0]           cnt_q;
  logic                  phase_q;
  logic                  wr_blink;
  logic                  wr_div;

  assign wr_blink = avs_write && (avs_address == A_BLINK);
  assign wr_div   = avs_write && (avs_address == A_DIV);

  always_ff @(posedge clk) begin
    if (reset)
      blink_q <= '0;
    else if (wr_blink)
      blink_q <= avs_writedata[NUM_DIGITS-1:0];
  end

  // A divider of zero parks the display in the on phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= DIV_RST;
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else if (wr_div) begin
      div_q   <= avs_writedata;
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else if (div_q == 32'd0) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else if (cnt_q == div_q - 32'd1) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + 32'd1;
    end
  end

  assign phase     = phase_q;
  assign blink_off = blink_q & {NUM_DIGITS{~phase_q}};
`else
  localparam int unused_rates = CLK_HZ + BLINK_HZ;

  assign phase     = 1'b1;
  assign blink_off = '0;
`endif

  always_comb begin
    rd_d = 32'h0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (avs_address == 5'(i))
        rd_d = {24'h0, digit_q[i]};
    if (avs_address == A_BLANK)
      rd_d = 32'(blank_q);
`ifdef SEG_DISP_BLINK_EN
    if (avs_address == A_BLINK)
      rd_d = 32'(blink_q);
    if (avs_address == A_DIV)
      rd_d = div_q;
`endif
    if (avs_address == A_STATUS)
      rd_d = {19'h0, 5'(NUM_DIGITS), 7'h0, phase};
  end

  always_ff @(posedge clk) begin
    if (reset)
      avs_readdata <= 32'h0;
    else if (avs_read)
      avs_readdata <= rd_d;
    else
      avs_readdata <= 32'h0;
  end

  always_comb begin
    seg_d = '0;
    pat   = 7'h00;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (blank_q[i] || blink_off[i])
        pat = 7'h00;
      else if (digit_q[i][7])
        pat = digit_q[i][6:0];
      else
        pat = hex7(digit_q[i][3:0]);
      seg_d[7*i +: 7] = ACTIVE_LOW ? ~pat : pat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      seg_out <= {NUM_DIGITS{SEG_OFF}};
    else
      seg_out <= seg_d;
  end

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// Scoreboard bench for seg_disp_ctrl: directed register-map sequence then random traffic.
// Follows SEG_DISP_BLINK_EN the same way the design does.
module tb_seg_disp_ctrl;

  localparam int ND     = 7;
  localparam int CLK_HZ = 1000;
  localparam int BHZ    = 2;
  localparam bit AL     = 1;
`ifdef SEG_DISP_BLINK_EN
  localparam bit BLINK_EN = 1;
`else
  localparam bit BLINK_EN = 0;
`endif

  localparam logic [6:0] HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic              clk = 0;
  logic              reset = 1;
  logic [4:0]        avs_address = '0;
  logic              avs_write = 0;
  logic [31:0]       avs_writedata = '0;
  logic              avs_read = 0;
  logic [31:0]       avs_readdata;
  logic [ND*7-1:0]   seg_out;

  seg_disp_ctrl #(
    .NUM_DIGITS(ND), .CLK_HZ(CLK_HZ), .BLINK_HZ(BHZ), .ACTIVE_LOW(AL)
  ) dut (
    .clk(clk), .reset(reset),
    .avs_address(avs_address), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_read(avs_read),
    .avs_readdata(avs_readdata), .seg_out(seg_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;

  logic [ND*7-1:0] seg_q [$];
  logic [31:0]     rd_q  [$];

  // Behavioural model: register contents plus edges elapsed since the
  // divider was last (re)loaded; blink phase follows from that count.
  logic [7:0]      m_dig [ND];
  logic [ND-1:0]   m_blank;
  logic [ND-1:0]   m_blink;
  logic [31:0]     m_div;
  int unsigned     m_ticks;
  logic            m_div_wr;
  logic            ph;
  logic [ND*7-1:0] es;
  logic [31:0]     er;

  function automatic logic m_phase();
    if (!BLINK_EN || m_div == 0) return 1'b1;
    return ((m_ticks / m_div) % 2) == 0;
  endfunction

  function automatic logic [6:0] m_seg(input int i, input logic p);
    logic [6:0] s;
    if (m_blank[i]) s = 7'h00;
    else if (BLINK_EN && m_blink[i] && !p) s = 7'h00;
    else if (m_dig[i][7]) s = m_dig[i][6:0];
    else s = HEX[m_dig[i][3:0]];
    return AL ? ~s : s;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic p);
    if (int'(a) < ND) return {24'h0, m_dig[int'(a)]};
    if (a == 5'd16) return 32'(m_blank);
    if (a == 5'd17) return BLINK_EN ? 32'(m_blink) : 32'h0;
    if (a == 5'd18) return BLINK_EN ? m_div : 32'h0;
    if (a == 5'd19) return {19'h0, 5'(ND), 7'h0, p};
    return 32'h0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < ND; i++) m_dig[i] = 8'h00;
    m_blank = '1;
    m_blink = '0;
    m_div   = CLK_HZ / (2 * BHZ);
    m_ticks = 0;
  endtask

  always @(posedge clk) begin
    ph = m_phase();
    es = '0;
    er = 32'h0;
    if (reset) begin
      es = AL ? '1 : '0;
    end else begin
      for (int i = 0; i < ND; i++) es[7*i +: 7] = m_seg(i, ph);
      if (avs_read) er = m_read(avs_address, ph);
    end
    seg_q.push_back(es);
    rd_q.push_back(er);
    if (reset) begin
      m_reset();
    end else begin
      m_div_wr = 1'b0;
      if (avs_write) begin
        if (int'(avs_address) < ND)
          m_dig[int'(avs_address)] = avs_writedata[7:0];
        else if (avs_address == 5'd16)
          m_blank = avs_writedata[ND-1:0];
        else if (BLINK_EN && avs_address == 5'd17)
          m_blink = avs_writedata[ND-1:0];
        else if (BLINK_EN && avs_address == 5'd18) begin
          m_div    = avs_writedata;
          m_div_wr = 1'b1;
        end
      end
      m_ticks = m_div_wr ? 0 : m_ticks + 1;
    end
  end

  always @(negedge clk) begin
    logic [ND*7-1:0] xs;
    logic [31:0]     xr;
    cyc_n++;
    if (seg_q.size() > 0) begin
      xs = seg_q.pop_front();
      checks++;
      if (seg_out !== xs) begin
        errors++;
        $display("FAIL seg_out cyc=%0d got=%h exp=%h", cyc_n, seg_out, xs);
      end
    end
    if (rd_q.size() > 0) begin
      xr = rd_q.pop_front();
      checks++;
      if (avs_readdata !== xr) begin
        errors++;
        $display("FAIL readdata cyc=%0d got=%h exp=%h", cyc_n, avs_readdata, xr);
      end
    end
  end

  task automatic cyc(input logic r, input logic w, input logic rd,
                     input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    reset = r;
    avs_write = w;
    avs_read = rd;
    avs_address = a;
    avs_writedata = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 5'd0, 32'h0);
  endtask

  initial begin
    logic [4:0]  a;
    logic [31:0] d;
    m_reset();
    cyc(1, 0, 0, 5'd0, 32'h0);
    cyc(1, 0, 0, 5'd0, 32'h0);
    cyc(0, 0, 1, 5'd16, 32'h0);
    cyc(0, 0, 1, 5'd18, 32'h0);
    cyc(0, 0, 1, 5'd19, 32'h0);
    cyc(0, 1, 0, 5'd16, 32'h0);
    cyc(0, 1, 0, 5'd0, 32'h5);
    idle(2);
    cyc(0, 0, 1, 5'd0, 32'h0);
    cyc(0, 1, 0, 5'd3, 32'hC9);
    cyc(0, 0, 1, 5'd25, 32'h0);
    cyc(0, 1, 0, 5'd25, 32'hFF);
    cyc(0, 0, 1, 5'd3, 32'h0);
    cyc(0, 1, 0, 5'd18, 32'h4);
    cyc(0, 1, 0, 5'd17, 32'h1);
    cyc(0, 1, 0, 5'd0, 32'h8);
    for (int i = 0; i < 20; i++) cyc(0, 0, 1, 5'd19, 32'h0);
    cyc(0, 1, 0, 5'd18, 32'h0);
    idle(10);
    cyc(0, 1, 0, 5'd2, 32'h1);
    cyc(0, 1, 1, 5'd2, 32'h2);
    cyc(0, 0, 1, 5'd2, 32'h0);
    cyc(0, 1, 0, 5'd18, 32'h3);
    cyc(0, 1, 0, 5'd17, 32'h2);
    cyc(0, 1, 0, 5'd1, 32'h3);
    idle(4);
    cyc(1, 1, 0, 5'd1, 32'h7);
    cyc(0, 0, 1, 5'd1, 32'h0);
    cyc(0, 0, 1, 5'd19, 32'h0);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0)
        a = 5'($urandom_range(0, 31));
      else if ($urandom_range(0, 1) == 0)
        a = 5'($urandom_range(0, ND - 1));
      else
        a = 5'($urandom_range(16, 19));
      d = (a == 5'd18) ? 32'($urandom_range(0, 6)) : $urandom;
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 1) == 1, a, d);
    end
    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
